// File: rtl/proc_pkg.sv
// Shared constants for the simple processor control unit: opcodes,
// FSM state encoding and bus-select codes.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;

    // Bus-select code for general register R0-R7
    function automatic logic [3:0] reg_sel(input logic [2:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives the register load strobes.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    // Raise exactly one bit for the addressed register, none when disabled
    always_comb begin
        onehot = 8'b0000_0000;
        if (en) begin
            case (idx)
                3'd0:    onehot = 8'b0000_0001;
                3'd1:    onehot = 8'b0000_0010;
                3'd2:    onehot = 8'b0000_0100;
                3'd3:    onehot = 8'b0000_1000;
                3'd4:    onehot = 8'b0001_0000;
                3'd5:    onehot = 8'b0010_0000;
                3'd6:    onehot = 8'b0100_0000;
                3'd7:    onehot = 8'b1000_0000;
                default: onehot = 8'b0000_0000;
            endcase
        end else begin
            onehot = 8'b0000_0000;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Control FSM for the 16-bit bus datapath. Fetches a 9-bit instruction
// from din[15:7] in T0 and sequences bus source / load enables through
// T1..T3. Outputs are decoded combinationally from state and IR.
module proc_control
    import proc_pkg::*;
#(
    parameter int word = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [word-1:0] din,
    output logic [3:0]      select,
    output logic [7:0]      r_in,
    output logic            a_in,
    output logic            g_in,
    output logic            add_sub,
    output logic            ir_in,
    output logic            done
);

    state_t     state_r;
    state_t     state_next_s;
    logic [8:0] ir_r;
    logic [2:0] op_s;
    logic [2:0] x_s;
    logic [2:0] y_s;
    logic       r_en_s;
    logic       din_unused_s;

    // Low instruction bits carry nothing at fetch
    assign din_unused_s = ^din[word-10:0];

    assign op_s = ir_r[8:6];
    assign x_s  = ir_r[5:3];
    assign y_s  = ir_r[2:0];

    // Reset term keeps the strobe low while the FSM is being forced idle
    assign ir_in = run & (state_r == T0) & ~reset;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= T0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register, captured only on an accepted fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_r <= 9'd0;
        end else if (ir_in) begin
            ir_r <= din[word-1:word-9];
        end else begin
            ir_r <= ir_r;
        end
    end

    // Next-state and output decode from current state and IR fields
    always_comb begin
        state_next_s = state_r;
        select       = SEL_NONE;
        r_en_s       = 1'b0;
        a_in         = 1'b0;
        g_in         = 1'b0;
        add_sub      = 1'b0;
        done         = 1'b0;
        case (state_r)
            T0: begin
                if (run) begin
                    state_next_s = T1;
                end else begin
                    state_next_s = T0;
                end
            end
            T1: begin
                case (op_s)
                    OP_MV: begin
                        select       = reg_sel(y_s);
                        r_en_s       = 1'b1;
                        done         = 1'b1;
                        state_next_s = T0;
                    end
                    OP_MVI: begin
                        select       = SEL_DIN;
                        r_en_s       = 1'b1;
                        done         = 1'b1;
                        state_next_s = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        select       = reg_sel(x_s);
                        a_in         = 1'b1;
                        state_next_s = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as a one-cycle no-op
                        done         = 1'b1;
                        state_next_s = T0;
                    end
                endcase
            end
            T2: begin
                select       = reg_sel(y_s);
                g_in         = 1'b1;
                state_next_s = T3;
                if (op_s == OP_SUB) begin
                    add_sub = 1'b1;
                end else begin
                    add_sub = 1'b0;
                end
            end
            T3: begin
                select       = SEL_G;
                r_en_s       = 1'b1;
                done         = 1'b1;
                state_next_s = T0;
            end
            default: begin
                state_next_s = T0;
            end
        endcase
    end

    dec3to8 u_dec (
        .en     (r_en_s),
        .idx    (x_s),
        .onehot (r_in)
    );

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed literal cases plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_proc_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run   = 1'b0;
    logic [15:0] din   = 16'd0;
    logic [3:0]  select;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        add_sub;
    logic        ir_in;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] r;
        logic       a;
        logic       g;
        logic       as;
        logic       dn;
    } step_t;

    step_t q[$];

    proc_control #(.word(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .select  (select),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .ir_in   (ir_in),
        .done    (done)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] act_vec();
        return {select, r_in, a_in, g_in, add_sub, done, ir_in};
    endfunction

    // Model: each accepted fetch expands into the list of cycles it occupies
    initial begin : model
        step_t       cur;
        logic        exp_ir;
        logic [16:0] exp_v;
        logic [8:0]  ir;
        logic [7:0]  onehot;
        forever begin
            @(negedge clock);
            if (reset) begin
                cur    = '{sel: 4'd15, r: 8'd0, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b0};
                exp_ir = 1'b0;
            end else if (q.size() > 0) begin
                cur    = q[0];
                exp_ir = 1'b0;
            end else begin
                cur    = '{sel: 4'd15, r: 8'd0, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b0};
                exp_ir = run;
            end
            exp_v = {cur, exp_ir};
            n_checks++;
            if (act_vec() === exp_v) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t: got %h expected %h", $time, act_vec(), exp_v);
            end
            @(posedge clock);
            if (reset) begin
                q.delete();
            end else if (q.size() > 0) begin
                void'(q.pop_front());
            end else if (run) begin
                ir     = din[15:7];
                onehot = 8'd1 << ir[5:3];
                case (ir[8:6])
                    3'd0: q.push_back('{sel: {1'b0, ir[2:0]}, r: onehot, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b1});
                    3'd1: q.push_back('{sel: 4'd9, r: onehot, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b1});
                    3'd2, 3'd3: begin
                        q.push_back('{sel: {1'b0, ir[5:3]}, r: 8'd0, a: 1'b1, g: 1'b0, as: 1'b0, dn: 1'b0});
                        q.push_back('{sel: {1'b0, ir[2:0]}, r: 8'd0, a: 1'b0, g: 1'b1, as: ir[6], dn: 1'b0});
                        q.push_back('{sel: 4'd8, r: onehot, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b1});
                    end
                    default: q.push_back('{sel: 4'd15, r: 8'd0, a: 1'b0, g: 1'b0, as: 1'b0, dn: 1'b1});
                endcase
            end
        end
    end

    task automatic drive(input logic r, input logic [15:0] d);
        @(posedge clock);
        #1;
        run = r;
        din = d;
    endtask

    task automatic check_now(input string name, input logic [3:0] sel, input logic [7:0] r,
                             input logic a, input logic g, input logic as, input logic dn,
                             input logic ir);
        logic [16:0] exp_v;
        exp_v = {sel, r, a, g, as, dn, ir};
        n_checks++;
        if (act_vec() === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act_vec(), exp_v);
        end
    endtask

    task automatic expect_lit(input string name, input logic [3:0] sel, input logic [7:0] r,
                              input logic a, input logic g, input logic as, input logic dn,
                              input logic ir);
        @(negedge clock);
        #1;
        check_now(name, sel, r, a, g, as, dn, ir);
    endtask

    initial begin : stim
        // Reset with run held high: strobe must stay low
        run = 1'b1;
        din = {9'b000_000_111, 7'd0};
        expect_lit("reset_idle", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        expect_lit("post_reset_idle", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mvi R5, #A5
        drive(1'b1, {9'b001_101_000, 7'd0});
        expect_lit("mvi_fetch", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 16'h00A5);
        expect_lit("mvi_t1", 4'd9, 8'b0010_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // mv R0, R7
        drive(1'b1, {9'b000_000_111, 7'd0});
        drive(1'b0, 16'd0);
        expect_lit("mv_t1", 4'd7, 8'b0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("mv_back_t0", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // add R3, R4
        drive(1'b1, {9'b010_011_100, 7'd0});
        drive(1'b0, 16'd0);
        expect_lit("add_t1", 4'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("add_t2", 4'd4, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("add_t3", 4'd8, 8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // sub R6, R1 with run toggling mid-instruction
        drive(1'b1, {9'b011_110_001, 7'd0});
        drive(1'b1, {9'b000_111_111, 7'd0});
        expect_lit("sub_t1", 4'd6, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("sub_t2", 4'd1, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, {9'b001_000_000, 7'd0});
        expect_lit("sub_t3", 4'd8, 8'b0100_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("sub_back_t0", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reserved op, then run held high: fetch on every T0
        drive(1'b1, {9'b110_010_011, 7'd0});
        expect_lit("rsv_fetch", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, {9'b000_010_001, 7'd0});
        expect_lit("rsv_t1", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, {9'b000_010_001, 7'd0});
        expect_lit("hold_run_fetch", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, {9'b111_000_000, 7'd0});
        expect_lit("hold_run_mv_t1", 4'd1, 8'b0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("hold_run_idle", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // add R1, R2 aborted by reset in T2
        drive(1'b1, {9'b010_001_010, 7'd0});
        drive(1'b0, 16'd0);
        expect_lit("abort_t1", 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("abort_t2", 4'd2, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_now("abort_same_cycle", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        expect_lit("abort_after_1", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0);
        expect_lit("abort_after_2", 4'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clock);
            #1;
            reset = ($urandom_range(0, 59) == 0);
            run   = ($urandom_range(0, 2) != 0);
            din   = 16'($urandom);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
